mxu_seq_ctrl: RTL

Sequencer for the 32x32 weight-stationary systolic array. It loads one weight row per cycle into the PE grid through per-row weight-reload strobes. It then streams a programmable number of input vectors from the activation buffer and drives result-capture valid/address toward the output buffer once the array pipeline has drained. It sits between the host command interface and the PE array, owning every array-side read enable, reload strobe and result strobe.

---
 rtl/mxu_pkg.sv | 26 ++
 rtl/mxu_valid_dly.sv | 37 +++
 rtl/mxu_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mxu_pkg.sv
// Shared constants, FSM state encoding and helpers for the systolic-array sequencer.
// The optional MXU_CTRL_WEIGHT_SKIP_EN macro is consumed by mxu_seq_ctrl, not here.
package mxu_pkg;

    localparam int ARRAY_DIM  = 32;
    localparam int VEC_CNT_BW = 16;
    // Skew in plus deskew out across the square array.
    localparam int PIPE_LAT   = 2 * ARRAY_DIM;
    localparam int ROW_W      = $clog2(ARRAY_DIM);
    // One extra bit so the row counter can sit at ARRAY_DIM after the last issue.
    localparam int RCNT_W     = ROW_W + 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD_W = 3'd1;
    localparam state_t STREAM = 3'd2;
    localparam state_t DRAIN  = 3'd3;
    localparam state_t FIN    = 3'd4;

    function automatic logic [ARRAY_DIM-1:0] row_onehot(input logic [ROW_W-1:0] r);
        row_onehot    = '0;
        row_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/mxu_valid_dly.sv
// Fixed-depth shift register carrying a valid bit and an index alongside it.
// Used for the 1-cycle read-data alignment and the array pipeline latency.
module mxu_valid_dly #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [W-1:0] in_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_reg;
    logic [W-1:0]     idx_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_reg[i] <= '0;
            end
        end else begin
            vld_reg[0] <= in_valid;
            idx_reg[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                idx_reg[i] <= idx_reg[i-1];
            end
        end
    end

    assign out_valid = vld_reg[DEPTH-1];
    assign out_idx   = idx_reg[DEPTH-1];

endmodule

// File: rtl/mxu_seq_ctrl.sv
// Weight-load / vector-stream / result-drain sequencer for the 32x32 systolic array.
// Define MXU_CTRL_WEIGHT_SKIP_EN to let keep_w=1 reuse weights from the last completed load.
module mxu_seq_ctrl
    import mxu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [VEC_CNT_BW-1:0] num_vec,
    input  logic                  keep_w,
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [ROW_W-1:0]      w_rd_addr,
    output logic [ARRAY_DIM-1:0]  we_rl_row,
    output logic                  d_rd_en,
    output logic [VEC_CNT_BW-1:0] d_rd_addr,
    output logic                  din_valid,
    output logic                  out_valid,
    output logic [VEC_CNT_BW-1:0] out_addr
);

    localparam logic [RCNT_W-1:0] ROW_LAST = RCNT_W'(ARRAY_DIM - 1);
    localparam logic [RCNT_W-1:0] ROW_END  = RCNT_W'(ARRAY_DIM);

    state_t                  state_reg, state_next;
    logic [RCNT_W-1:0]       row_reg, row_next;
    logic [VEC_CNT_BW-1:0]   vec_reg, vec_next;
    logic [VEC_CNT_BW-1:0]   last_reg, last_next;
    logic                    zero_reg, zero_next;
    logic                    skip_load;

    logic                    busy_reg, done_reg;
    logic                    w_rd_en_reg, w_rd_en_next;
    logic [ROW_W-1:0]        w_rd_addr_reg, w_rd_addr_next;
    logic [ARRAY_DIM-1:0]    we_rl_row_reg;
    logic                    d_rd_en_reg, d_rd_en_next;
    logic [VEC_CNT_BW-1:0]   d_rd_addr_reg, d_rd_addr_next;
    logic [VEC_CNT_BW-1:0]   din_idx;

`ifdef MXU_CTRL_WEIGHT_SKIP_EN
    logic w_valid_reg;

    // Empty commands always take the load path so they terminate through LOAD_W.
    assign skip_load = keep_w && w_valid_reg && (num_vec != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_valid_reg <= 1'b0;
        end else if (state_reg == LOAD_W && state_next != LOAD_W) begin
            w_valid_reg <= 1'b1;
        end
    end
`else
    logic unused_keep_w;

    assign unused_keep_w = keep_w;
    assign skip_load     = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        vec_next       = vec_reg;
        last_next      = last_reg;
        zero_next      = zero_reg;
        w_rd_en_next   = 1'b0;
        w_rd_addr_next = '0;
        d_rd_en_next   = 1'b0;
        d_rd_addr_next = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    last_next  = num_vec - VEC_CNT_BW'(1);
                    zero_next  = (num_vec == '0);
                    row_next   = '0;
                    vec_next   = '0;
                    state_next = skip_load ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                if (row_reg < ROW_END) begin
                    w_rd_en_next   = 1'b1;
                    w_rd_addr_next = row_reg[ROW_W-1:0];
                    row_next       = row_reg + RCNT_W'(1);
                end
                // With no vectors, finish only once the last reload strobe has gone out.
                if (!zero_reg && row_reg == ROW_LAST) begin
                    state_next = STREAM;
                end else if (zero_reg && row_reg == ROW_END && !w_rd_en_reg) begin
                    state_next = FIN;
                end
            end
            STREAM: begin
                d_rd_en_next   = 1'b1;
                d_rd_addr_next = vec_reg;
                if (vec_reg == last_reg) begin
                    state_next = DRAIN;
                end else begin
                    vec_next = vec_reg + VEC_CNT_BW'(1);
                end
            end
            DRAIN: begin
                if (out_valid && out_addr == last_reg) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            vec_reg       <= '0;
            last_reg      <= '0;
            zero_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            w_rd_en_reg   <= 1'b0;
            w_rd_addr_reg <= '0;
            we_rl_row_reg <= '0;
            d_rd_en_reg   <= 1'b0;
            d_rd_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            vec_reg       <= vec_next;
            last_reg      <= last_next;
            zero_reg      <= zero_next;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == FIN);
            w_rd_en_reg   <= w_rd_en_next;
            w_rd_addr_reg <= w_rd_addr_next;
            // Weight buffer data arrives one cycle after its address.
            we_rl_row_reg <= w_rd_en_reg ? row_onehot(w_rd_addr_reg) : '0;
            d_rd_en_reg   <= d_rd_en_next;
            d_rd_addr_reg <= d_rd_addr_next;
        end
    end

    mxu_valid_dly #(
        .DEPTH (1),
        .W     (VEC_CNT_BW)
    ) u_din_dly (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (d_rd_en_reg),
        .in_idx    (d_rd_addr_reg),
        .out_valid (din_valid),
        .out_idx   (din_idx)
    );

    mxu_valid_dly #(
        .DEPTH (PIPE_LAT),
        .W     (VEC_CNT_BW)
    ) u_out_dly (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (din_valid),
        .in_idx    (din_idx),
        .out_valid (out_valid),
        .out_idx   (out_addr)
    );

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign w_rd_en   = w_rd_en_reg;
    assign w_rd_addr = w_rd_addr_reg;
    assign we_rl_row = we_rl_row_reg;
    assign d_rd_en   = d_rd_en_reg;
    assign d_rd_addr = d_rd_addr_reg;

endmodule
